// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register-block RTL.
package rggen_rtl_pkg;

  localparam int unsigned RGGEN_MAX_DATA_WIDTH   = 64;
  localparam int unsigned RGGEN_MAX_STROBE_WIDTH = RGGEN_MAX_DATA_WIDTH / 8;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQUEST  = 2'b01,
    RESPONSE = 2'b10
  } rggen_apb_adapter_state;

  // Expand a byte strobe into a bit mask: bit b follows strobe[b/8].
  function automatic logic [RGGEN_MAX_DATA_WIDTH-1:0] rggen_expand_strobe(
    input logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [RGGEN_MAX_DATA_WIDTH-1:0] mask;
    for (int b = 0; b < int'(RGGEN_MAX_DATA_WIDTH); b++) begin
      mask[b] = strobe[b/8];
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_register_if.sv
// Request/response channel between the host adapter and one register.
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) ();

  logic                                request;
  logic [ADDRESS_WIDTH-1:0]            address;
  rggen_rtl_pkg::rggen_direction       direction;
  logic [DATA_WIDTH-1:0]               write_data;
  logic [DATA_WIDTH-1:0]               write_mask;
  logic                                ready;
  rggen_rtl_pkg::rggen_status          status;
  logic [DATA_WIDTH-1:0]               read_data;
  logic [DATA_WIDTH-1:0]               value;

  modport master (
    output request, address, direction, write_data, write_mask,
    input  ready, status, read_data, value
  );

  modport slave (
    input  request, address, direction, write_data, write_mask,
    output ready, status, read_data, value
  );

endinterface

// File: rtl/rggen_register_response_mux.sv
// Lowest-index priority select of the register answers.
module rggen_register_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int TOTAL_REGISTERS = 1,
  parameter int DATA_WIDTH      = 32
) (
  input  logic [TOTAL_REGISTERS-1:0] i_ready,
  input  logic [DATA_WIDTH-1:0]      i_read_data [TOTAL_REGISTERS],
  input  rggen_status                i_status    [TOTAL_REGISTERS],
  output logic                       o_hit_c,
  output logic [DATA_WIDTH-1:0]      o_read_data_c,
  output rggen_status                o_status_c
);

  // Scan from the top so the lowest ready index is the last writer.
  always_comb begin
    o_hit_c       = 1'b0;
    o_read_data_c = '0;
    o_status_c    = RGGEN_OKAY;
    for (int i = TOTAL_REGISTERS - 1; i >= 0; i--) begin
      if (i_ready[i]) begin
        o_hit_c       = 1'b1;
        o_read_data_c = i_read_data[i];
        o_status_c    = i_status[i];
      end
    end
  end

endmodule

// File: rtl/rggen_apb_host_adapter.sv
// APB3/APB4 completer bridged onto an array of rggen register channels.
module rggen_apb_host_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter bit ERROR_ON_NO_HIT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic                      i_pwrite,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
  output logic                      o_pready,
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pslverr,
  rggen_register_if.master          register_if [TOTAL_REGISTERS]
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  rggen_apb_adapter_state          r_state;
  logic                            r_request;
  logic [ADDRESS_WIDTH-1:0]        r_address;
  rggen_direction                  r_direction;
  logic [DATA_WIDTH-1:0]           r_write_data;
  logic [DATA_WIDTH-1:0]           r_write_mask;
  logic                            r_pready;
  logic [DATA_WIDTH-1:0]           r_prdata;
  logic                            r_pslverr;

  logic                            w_setup;
  logic [RGGEN_MAX_DATA_WIDTH-1:0] w_strobe_full;
  logic [DATA_WIDTH-1:0]           w_strobe_mask;
  logic [TOTAL_REGISTERS-1:0]      w_ready;
  logic [DATA_WIDTH-1:0]           w_read_data [TOTAL_REGISTERS];
  rggen_status                     w_status    [TOTAL_REGISTERS];
  logic [TOTAL_REGISTERS-1:0]      w_value_parity;
  logic                            w_hit;
  logic [DATA_WIDTH-1:0]           w_sel_data;
  rggen_status                     w_sel_status;
  logic                            w_unused;

  assign w_setup       = i_psel && !i_penable;
  assign w_strobe_full = rggen_expand_strobe(RGGEN_MAX_STROBE_WIDTH'(i_pstrb));
  assign w_strobe_mask = w_strobe_full[DATA_WIDTH-1:0];

  // Broadcast the latched request to every channel and gather the answers.
  for (genvar g = 0; g < TOTAL_REGISTERS; g++) begin : g_channel
    assign register_if[g].request    = r_request;
    assign register_if[g].address    = r_address;
    assign register_if[g].direction  = r_direction;
    assign register_if[g].write_data = r_write_data;
    assign register_if[g].write_mask = r_write_mask;
    assign w_ready[g]                = register_if[g].ready;
    assign w_read_data[g]            = register_if[g].read_data;
    assign w_status[g]               = register_if[g].status;
    assign w_value_parity[g]         = ^register_if[g].value;
  end

  // Register values and the strobe bits above the bus width are not needed here.
  assign w_unused = ^{w_strobe_full, w_value_parity, STRB_WIDTH[0]};

  rggen_register_response_mux #(
    .TOTAL_REGISTERS (TOTAL_REGISTERS),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_response_mux (
    .i_ready       (w_ready),
    .i_read_data   (w_read_data),
    .i_status      (w_status),
    .o_hit_c       (w_hit),
    .o_read_data_c (w_sel_data),
    .o_status_c    (w_sel_status)
  );

  // Transfer FSM: latch setup, one request cycle, one response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_request    <= 1'b0;
      r_address    <= '0;
      r_direction  <= RGGEN_READ;
      r_write_data <= '0;
      r_write_mask <= '0;
      r_pready     <= 1'b0;
      r_prdata     <= '0;
      r_pslverr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state      <= REQUEST;
            r_request    <= 1'b1;
            r_address    <= i_paddr;
            r_direction  <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
            r_write_data <= i_pwdata;
            r_write_mask <= i_pwrite ? w_strobe_mask : '1;
          end
        end
        REQUEST: begin
          r_state   <= RESPONSE;
          r_request <= 1'b0;
          r_pready  <= 1'b1;
          r_prdata  <= (w_hit && (r_direction == RGGEN_READ)) ? w_sel_data : '0;
          r_pslverr <= w_hit ? (w_sel_status != RGGEN_OKAY) : ERROR_ON_NO_HIT;
        end
        RESPONSE: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_request <= 1'b0;
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  assign o_pready  = r_pready;
  assign o_prdata  = r_prdata;
  assign o_pslverr = r_pslverr;

endmodule
